// File: rtl/instruction_fetch.sv
// Program counter and fetch stage in front of a combinational instruction ROM.
// Registers the ROM word for decode behind a valid/ready handshake, with redirect, stall and halt.
module instruction_fetch #(
   parameter int unsigned          ADDR_BITS = 8,
   parameter int unsigned          DATA_BITS = 8,
   parameter logic [ADDR_BITS-1:0] RESET_PC  = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic [ADDR_BITS-1:0]   rom_addr,
   input  logic [2*DATA_BITS-1:0] rom_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2*DATA_BITS-1:0] out_instr,
   output logic [ADDR_BITS-1:0]   out_pc,
   input  logic                   redirect_valid,
   input  logic [ADDR_BITS-1:0]   redirect_addr,
   input  logic                   halt_req,
   output logic                   halted
);

   typedef enum logic [0:0] {StRun, StHalted} state_e;

   state_e                 state_q, state_d;
   logic [ADDR_BITS-1:0]   pc_q, pc_d;
   logic                   valid_q, valid_d;
   logic [2*DATA_BITS-1:0] instr_q, instr_d;
   logic [ADDR_BITS-1:0]   opc_q, opc_d;
   logic                   halted_q, halted_d;
   logic                   out_free;
   logic                   fetch;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      valid_d  = valid_q;
      instr_d  = instr_q;
      opc_d    = opc_q;
      out_free = !valid_q || out_ready;
      fetch    = (state_q == StRun) && !redirect_valid && !halt_req && out_free;

      // halt_req wins over redirect for the next state; redirect still loads the pc
      if (halt_req) begin
         state_d = StHalted;
      end else if (redirect_valid) begin
         state_d = StRun;
      end

      if (redirect_valid) begin
         pc_d    = redirect_addr;
         valid_d = 1'b0;
      end else if (fetch) begin
         pc_d    = pc_q + ADDR_BITS'(1);
         valid_d = 1'b1;
         instr_d = rom_data;
         opc_d   = pc_q;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end

      halted_d = (state_d == StHalted);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StRun;
         pc_q     <= RESET_PC;
         valid_q  <= 1'b0;
         instr_q  <= '0;
         opc_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         valid_q  <= valid_d;
         instr_q  <= instr_d;
         opc_q    <= opc_d;
         halted_q <= halted_d;
      end
   end

   assign rom_addr  = pc_q;
   assign out_valid = valid_q;
   assign out_instr = instr_q;
   assign out_pc    = opc_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios then randomized traffic,
// all compared against a transaction-level reference model.
module tb_instruction_fetch;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_instr;
   logic [7:0]  out_pc;
   logic        redirect_valid;
   logic [7:0]  redirect_addr;
   logic        halt_req;
   logic        halted;

   int n_tests;
   int n_fail;

   // reference model state
   logic [7:0]  m_pc;
   logic        m_valid;
   logic [15:0] m_instr;
   logic [7:0]  m_out_pc;
   logic        m_halted;

   instruction_fetch #(
      .ADDR_BITS (8),
      .DATA_BITS (8),
      .RESET_PC  (8'h00)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .halt_req       (halt_req),
      .halted         (halted)
   );

   function automatic logic [15:0] rom(input logic [7:0] a);
      return 16'hA000 + {8'h00, a};
   endfunction

   assign rom_data = rom(rom_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc     = 8'h00;
      m_valid  = 1'b0;
      m_instr  = 16'h0000;
      m_out_pc = 8'h00;
      m_halted = 1'b0;
   endtask

   // One clock of the stage described as a transaction: what happens to the pending
   // instruction and whether a new one is taken from the ROM.
   task automatic model_step();
      logic accepted;
      accepted = m_valid && out_ready;
      if (redirect_valid) begin
         m_pc     = redirect_addr;
         m_valid  = 1'b0;
         m_halted = halt_req;
      end else if (m_halted || halt_req) begin
         m_halted = 1'b1;
         if (accepted) m_valid = 1'b0;
      end else if (!m_valid || accepted) begin
         m_out_pc = m_pc;
         m_instr  = rom(m_pc);
         m_valid  = 1'b1;
         m_pc     = m_pc + 8'd1;
      end
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_valid});
      check_eq({tag, ".pc"}, {24'd0, out_pc}, {24'd0, m_out_pc});
      check_eq({tag, ".instr"}, {16'd0, out_instr}, {16'd0, m_instr});
      check_eq({tag, ".rom_addr"}, {24'd0, rom_addr}, {24'd0, m_pc});
      check_eq({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic drive(input logic rdy, input logic rv, input logic [7:0] ra, input logic hr);
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_addr  = ra;
      halt_req       = hr;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      model_reset();
      cycle("reset");
      cycle("reset");
      rst_n = 1'b1;

      // stream from RESET_PC
      for (int i = 0; i < 6; i++) begin
         cycle("stream");
         check_eq("stream.seq_pc", {24'd0, out_pc}, i);
         check_eq("stream.seq_instr", {16'd0, out_instr}, 32'hA000 + i);
      end

      // stall while out_pc=5
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle("stall");
         check_eq("stall.instr", {16'd0, out_instr}, 32'hA005);
         check_eq("stall.rom_addr", {24'd0, rom_addr}, 32'h6);
      end
      out_ready = 1'b1;
      cycle("unstall");
      check_eq("unstall.pc", {24'd0, out_pc}, 32'h6);
      cycle("unstall");

      // redirect under back-pressure
      drive(1'b0, 1'b1, 8'h40, 1'b0);
      cycle("redir");
      check_eq("redir.bubble", {31'd0, out_valid}, 32'd0);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      cycle("redir");
      check_eq("redir.target", {16'd0, out_instr}, 32'hA040);
      cycle("redir");

      // wrap around the top of the address space
      drive(1'b1, 1'b1, 8'hFE, 1'b0);
      cycle("wrap");
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle("wrap");
         check_eq("wrap.seq_pc", {24'd0, out_pc}, (32'hFE + i) & 32'hFF);
      end

      // halt with a pending instruction, then resume by redirect
      drive(1'b1, 1'b1, 8'h10, 1'b0);
      cycle("halt");
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      cycle("halt");
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      cycle("halt");
      check_eq("halt.kept", {31'd0, out_valid}, 32'd1);
      check_eq("halt.flag", {31'd0, halted}, 32'd1);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      cycle("halt");
      out_ready = 1'b1;
      cycle("halt");
      check_eq("halt.drained", {31'd0, out_valid}, 32'd0);
      check_eq("halt.rom_addr", {24'd0, rom_addr}, 32'h11);
      cycle("halt");
      drive(1'b1, 1'b1, 8'h20, 1'b0);
      cycle("resume");
      check_eq("resume.halted", {31'd0, halted}, 32'd0);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      cycle("resume");
      check_eq("resume.pc", {24'd0, out_pc}, 32'h20);

      // simultaneous redirect and halt
      drive(1'b1, 1'b1, 8'h30, 1'b1);
      cycle("rh");
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      cycle("rh");
      check_eq("rh.rom_addr", {24'd0, rom_addr}, 32'h30);
      check_eq("rh.halted", {31'd0, halted}, 32'd1);

      // resume, stream, then asynchronous reset between edges
      drive(1'b1, 1'b1, 8'h30, 1'b0);
      cycle("pre_rst");
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      cycle("pre_rst");
      cycle("pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      cycle("async_rst");
      @(negedge clk);
      rst_n = 1'b1;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
               8'($urandom_range(0, 255)), $urandom_range(0, 19) == 0);
         cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
